// File: rtl/bcd_pkg.sv
// Shared BCD arithmetic package.
// Purpose : common digit type, radix constant and subtractor FSM encoding,
//           used by the serial BCD subtractor (and the serial BCD adder).
// Contents: bcd_digit_t, BCD_RADIX, bcd_sub_state_t.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int BCD_RADIX = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } bcd_sub_state_t;

endpackage

// File: rtl/bcd_serial_subtractor_if.sv
// Bus interface of the serial BCD subtractor.
// Purpose : groups the operand/launch/result signals between the register
//           block (master) and the subtract engine (slave).
// Signals : arg1, arg2 (operands), start (launch), busy, done (status),
//           borrow, invalid (flags), result (packed-BCD difference).
interface bcd_serial_subtractor_if #(
  parameter int ARG_WIDTH = 32
);
  logic [ARG_WIDTH-1:0] arg1;
  logic [ARG_WIDTH-1:0] arg2;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 borrow;
  logic                 invalid;
  logic [ARG_WIDTH-1:0] result;

  modport master (
    output arg1, arg2, start,
    input  busy, done, borrow, invalid, result
  );

  modport slave (
    input  arg1, arg2, start,
    output busy, done, borrow, invalid, result
  );
endinterface

// File: rtl/bcd_digit_subtractor.sv
// Single-digit BCD subtract cell (combinational).
// Purpose : digit = a - b - bi in decimal with borrow; shared by the SUB
//           pass and the NEG (0 - result) pass of the serial subtractor.
// Ports   : a, b  (in, 4)  minuend / subtrahend digit
//           bi    (in, 1)  borrow in
//           digit (out, 4) difference digit
//           bo    (out, 1) borrow out
//           bad   (out, 1) either input nibble is not a decimal digit
module bcd_digit_subtractor
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       bi,
  output bcd_digit_t digit,
  output logic       bo,
  output logic       bad
);

  logic [4:0] a_ext;
  logic [4:0] sub_ext;
  logic [4:0] diff;

  always_comb begin
    a_ext   = {1'b0, a};
    sub_ext = {1'b0, b} + {4'd0, bi};
    bo      = (a_ext < sub_ext);
    // On borrow add the radix back; the 5-bit wrap gives the mod-16 result
    // for out-of-range nibbles as well.
    if (bo) begin
      diff = a_ext + 5'(BCD_RADIX) - sub_ext;
    end else begin
      diff = a_ext - sub_ext;
    end
    digit = diff[3:0];
    bad   = (a > 4'd9) || (b > 4'd9);
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Serial packed-BCD subtractor: result = arg1 - arg2, one digit per clock,
// least-significant digit first.
// Purpose : subtract engine of the BCD arithmetic unit. A start seen in IDLE
//           latches the operands; DIGITS digit cycles follow (busy high),
//           then a one-cycle DONE state pulses done with result/flags valid.
// Ports   : clk   (in)  clock, all state on posedge
//           reset (in)  synchronous active-high reset
//           bus   (slave modport of bcd_serial_subtractor_if):
//             arg1/arg2 in, start in, busy/done/borrow/invalid/result out
// Config  : `BCD_SUB_SIGNED_MAG_EN defined -> a negative difference is
//           re-run as 0 - result (NEG pass) so result holds |arg1-arg2| and
//           borrow marks the sign. Undefined -> result is the ten's
//           complement difference mod 10^DIGITS.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int ARG_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  bcd_serial_subtractor_if.slave  bus
);

  localparam int                DIGITS   = ARG_WIDTH / 4;
  localparam int                IDX_W    = $clog2(DIGITS + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);

  bcd_sub_state_t       state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 bi_q, bi_d;
  logic                 inv_run_q, inv_run_d;
  logic [ARG_WIDTH-1:0] a_sh_q, a_sh_d;
  logic [ARG_WIDTH-1:0] b_sh_q, b_sh_d;
  logic [ARG_WIDTH-1:0] work_q, work_d;
  logic [ARG_WIDTH-1:0] result_q, result_d;
  logic                 borrow_q, borrow_d;
  logic                 invalid_q, invalid_d;

  bcd_digit_t           dig;
  logic                 dig_bo;
  logic                 dig_bad;
  logic                 last_step;
  logic                 neg_needed;
  logic [ARG_WIDTH-1:0] work_next;

  bcd_digit_subtractor u_digit (
    .a     (a_sh_q[3:0]),
    .b     (b_sh_q[3:0]),
    .bi    (bi_q),
    .digit (dig),
    .bo    (dig_bo),
    .bad   (dig_bad)
  );

  assign last_step = (idx_q == LAST_IDX);
  // New digit enters at the top; after DIGITS shifts digit i sits at [4i+3:4i].
  assign work_next = {dig, work_q[ARG_WIDTH-1:4]};

`ifdef BCD_SUB_SIGNED_MAG_EN
  assign neg_needed = dig_bo;
`else
  assign neg_needed = 1'b0;
`endif

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = SUB;
      SUB:  if (last_step) state_d = neg_needed ? NEG : DONE;
      NEG:  if (last_step) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- outputs ----
  always_comb begin
    bus.busy    = (state_q == SUB) || (state_q == NEG);
    bus.done    = (state_q == DONE);
    bus.borrow  = borrow_q;
    bus.invalid = invalid_q;
    bus.result  = result_q;
  end

  // ---- datapath next values ----
  always_comb begin
    idx_d     = idx_q;
    bi_d      = bi_q;
    inv_run_d = inv_run_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    work_d    = work_q;
    result_d  = result_q;
    borrow_d  = borrow_q;
    invalid_d = invalid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d    = bus.arg1;
          b_sh_d    = bus.arg2;
          idx_d     = '0;
          bi_d      = 1'b0;
          inv_run_d = 1'b0;
        end
      end
      SUB, NEG: begin
        a_sh_d = a_sh_q >> 4;
        b_sh_d = b_sh_q >> 4;
        work_d = work_next;
        bi_d   = dig_bo;
        idx_d  = idx_q + IDX_W'(1);
        // Only the user operands are checked; the NEG pass operands are ours.
        if (state_q == SUB) begin
          inv_run_d = inv_run_q | dig_bad;
        end
        if (last_step) begin
          idx_d = '0;
          if ((state_q == SUB) && neg_needed) begin
            // Reload for 0 - difference to obtain the magnitude.
            a_sh_d = '0;
            b_sh_d = work_next;
            bi_d   = 1'b0;
          end else begin
            result_d  = work_next;
            // NEG is only ever entered with a negative difference.
            borrow_d  = (state_q == SUB) ? dig_bo : 1'b1;
            invalid_d = inv_run_d;
          end
        end
      end
      default: ;
    endcase
  end

  // ---- control and result registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q     <= '0;
      bi_q      <= 1'b0;
      inv_run_q <= 1'b0;
      result_q  <= '0;
      borrow_q  <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      bi_q      <= bi_d;
      inv_run_q <= inv_run_d;
      result_q  <= result_d;
      borrow_q  <= borrow_d;
      invalid_q <= invalid_d;
    end
  end

  // ---- operand and working shift registers ----
  always_ff @(posedge clk) begin
    a_sh_q <= a_sh_d;
    b_sh_q <= b_sh_d;
    work_q <= work_d;
  end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Testbench for bcd_serial_subtractor (ARG_WIDTH = 32).
module tb_bcd_serial_subtractor;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  bcd_serial_subtractor_if #(.ARG_WIDTH(32)) bus ();

  bcd_serial_subtractor #(.ARG_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic longint bcd2int(input logic [31:0] v);
    longint s = 0;
    for (int i = 7; i >= 0; i--) s = s * 10 + longint'(v[4*i +: 4]);
    return s;
  endfunction

  function automatic logic [31:0] int2bcd(input longint v);
    logic [31:0] r = '0;
    longint x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Literal digit rule, used only when a nibble is outside 0..9.
  function automatic void digit_rule(input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] r, output bit bo);
    int br = 0;
    int a, b;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      a = int'(x[4*i +: 4]);
      b = int'(y[4*i +: 4]);
      if (a < b + br) begin
        r[4*i +: 4] = 4'((a + 10 - b - br + 16) % 16);
        br = 1;
      end else begin
        r[4*i +: 4] = 4'(a - b - br);
        br = 0;
      end
    end
    bo = (br != 0);
  endfunction

  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output bit bo,
                                output bit inv, output int lat);
    longint d;
    logic [31:0] r2;
    bit dummy;
    inv = 1'b0;
    for (int i = 0; i < 8; i++)
      if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) inv = 1'b1;
    if (!inv) begin
      d  = bcd2int(x) - bcd2int(y);
      bo = (d < 0);
`ifdef BCD_SUB_SIGNED_MAG_EN
      r = int2bcd(bo ? -d : d);
`else
      r = int2bcd(bo ? d + 64'd100000000 : d);
`endif
    end else begin
      digit_rule(x, y, r, bo);
`ifdef BCD_SUB_SIGNED_MAG_EN
      if (bo) begin
        digit_rule(32'h0, r, r2, dummy);
        r = r2;
      end
`endif
    end
    lat = 9;
`ifdef BCD_SUB_SIGNED_MAG_EN
    if (bo) lat = 17;
`endif
    r2 = r;
    r  = r2;
  endfunction

  // ---------------- stimulus helper (no checking) ----------------
  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while ((bus.busy || bus.done) && g < 100) begin
      @(negedge clk);
      g++;
    end
  endtask

  // lat = cycle index (1 = first cycle after the accept edge) in which done is high; -1 on timeout.
  task automatic run_op(input logic [31:0] a1, input logic [31:0] a2,
                        output logic [31:0] res, output logic bo,
                        output logic inv, output int lat);
    wait_idle();
    bus.arg1  = a1;
    bus.arg2  = a2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done) lat = -1;
    res = bus.result;
    bo  = bus.borrow;
    inv = bus.invalid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_cmp++; if (bus.result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h expected 00000000", bus.result); end
    n_cmp++; if ({bus.borrow, bus.invalid} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b expected 00", {bus.borrow, bus.invalid}); end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] a1 [4];
    logic [31:0] a2 [4];
    logic [31:0] er [4];
    logic        eb [4];
    int          el [4];
    logic [31:0] r; logic b, iv; int lat;
    a1[0] = 32'h00001234; a2[0] = 32'h00000567; er[0] = 32'h00000667; eb[0] = 1'b0; el[0] = 9;
    a1[1] = 32'h00000100; a2[1] = 32'h00000001; er[1] = 32'h00000099; eb[1] = 1'b0; el[1] = 9;
    a1[2] = 32'h99999999; a2[2] = 32'h99999999; er[2] = 32'h00000000; eb[2] = 1'b0; el[2] = 9;
`ifdef BCD_SUB_SIGNED_MAG_EN
    a1[3] = 32'h00000001; a2[3] = 32'h00000002; er[3] = 32'h00000001; eb[3] = 1'b1; el[3] = 17;
`else
    a1[3] = 32'h00000001; a2[3] = 32'h00000002; er[3] = 32'h99999999; eb[3] = 1'b1; el[3] = 9;
`endif
    for (int k = 0; k < 4; k++) begin
      run_op(a1[k], a2[k], r, b, iv, lat);
      n_cmp++; if (r !== er[k]) begin n_bad++; $display("FAIL directed%0d_result: got %h expected %h", k, r, er[k]); end
      n_cmp++; if (b !== eb[k]) begin n_bad++; $display("FAIL directed%0d_borrow: got %b expected %b", k, b, eb[k]); end
      n_cmp++; if (iv !== 1'b0) begin n_bad++; $display("FAIL directed%0d_invalid: got %b expected 0", k, iv); end
      n_cmp++; if (lat != el[k]) begin n_bad++; $display("FAIL directed%0d_latency: got %0d expected %0d", k, lat, el[k]); end
      @(negedge clk);
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL directed%0d_done_pulse: got %b expected 0", k, bus.done); end
    end
  endtask

  task automatic test_invalid();
    logic [31:0] r; logic b, iv; int lat;
    run_op(32'h0000000A, 32'h00000000, r, b, iv, lat);
    n_cmp++; if (iv !== 1'b1) begin n_bad++; $display("FAIL invalid_set: got %b expected 1", iv); end
    n_cmp++; if (lat != 9) begin n_bad++; $display("FAIL invalid_done: got %0d expected 9", lat); end
    n_cmp++; if (r !== 32'h0000000A || b !== 1'b0) begin n_bad++; $display("FAIL invalid_result: got %h/%b expected 0000000a/0", r, b); end
    run_op(32'h00000042, 32'h00000017, r, b, iv, lat);
    n_cmp++; if (iv !== 1'b0) begin n_bad++; $display("FAIL invalid_clear: got %b expected 0", iv); end
    n_cmp++; if (r !== 32'h00000025) begin n_bad++; $display("FAIL invalid_next_result: got %h expected 00000025", r); end
  endtask

  function automatic logic [31:0] rand_bcd();
    logic [31:0] v = '0;
    for (int i = 0; i < 8; i++) v[4*i +: 4] = 4'($urandom_range(9));
    return v;
  endfunction

  task automatic test_random();
    logic [31:0] x, y, r, mr; logic b, iv; bit mb, mi; int lat, ml;
    for (int k = 0; k < 24; k++) begin
      if (k < 16) begin x = rand_bcd(); y = rand_bcd(); end
      else begin x = $urandom; y = $urandom; end
      model(x, y, mr, mb, mi, ml);
      run_op(x, y, r, b, iv, lat);
      n_cmp++;
      if (r !== mr || b !== mb || iv !== mi || lat != ml) begin
        n_bad++;
        $display("FAIL random%0d %h-%h: got %h b%b i%b lat%0d expected %h b%b i%b lat%0d",
                 k, x, y, r, b, iv, lat, mr, mb, mi, ml);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dc [$];
    wait_idle();
    bus.arg1  = 32'h00001234;
    bus.arg2  = 32'h00000567;
    bus.start = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (bus.done) begin
        dc.push_back(c);
        n_cmp++;
        if (bus.result !== 32'h00000667) begin n_bad++; $display("FAIL b2b_result: got %h expected 00000667", bus.result); end
      end
    end
    bus.start = 1'b0;
    n_cmp++; if (dc.size() != 3) begin n_bad++; $display("FAIL b2b_count: got %0d expected 3", dc.size()); end
    if (dc.size() >= 1) begin
      n_cmp++; if (dc[0] != 9) begin n_bad++; $display("FAIL b2b_first: got %0d expected 9", dc[0]); end
    end
    for (int i = 1; i < dc.size(); i++) begin
      n_cmp++;
      if (dc[i] - dc[i-1] != 10) begin n_bad++; $display("FAIL b2b_interval: got %0d expected 10", dc[i] - dc[i-1]); end
    end
    wait_idle();
  endtask

  task automatic test_arg_change();
    logic [31:0] x, y, mr; bit mb, mi; int ml, lat;
    x = rand_bcd(); y = rand_bcd();
    model(x, y, mr, mb, mi, ml);
    wait_idle();
    bus.arg1 = x; bus.arg2 = y; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat >= 2 && lat <= 5) begin
        bus.arg1 = $urandom; bus.arg2 = $urandom; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    n_cmp++; if (bus.result !== mr) begin n_bad++; $display("FAIL argchg_result: got %h expected %h", bus.result, mr); end
    n_cmp++; if (bus.borrow !== mb) begin n_bad++; $display("FAIL argchg_borrow: got %b expected %b", bus.borrow, mb); end
    n_cmp++; if (lat != ml) begin n_bad++; $display("FAIL argchg_latency: got %0d expected %0d", lat, ml); end
    repeat (2) begin
      @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL argchg_no_relaunch: got %b expected 0", bus.busy); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic b, iv; int lat;
    run_op(32'h00001234, 32'h00000567, r, b, iv, lat);
    n_cmp++; if (r !== 32'h00000667) begin n_bad++; $display("FAIL rstmid_pre: got %h expected 00000667", r); end
    wait_idle();
    bus.arg1 = 32'h00000001; bus.arg2 = 32'h00000002; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL rstmid_ctrl: got busy %b done %b expected 0 0", bus.busy, bus.done); end
    n_cmp++; if (bus.result !== 32'h0 || bus.borrow !== 1'b0) begin n_bad++; $display("FAIL rstmid_result: got %h/%b expected 00000000/0", bus.result, bus.borrow); end
    reset = 1'b0;
    run_op(32'h00005000, 32'h00000001, r, b, iv, lat);
    n_cmp++; if (r !== 32'h00004999 || b !== 1'b0 || lat != 9) begin n_bad++; $display("FAIL rstmid_fresh: got %h/%b lat %0d expected 00004999/0 lat 9", r, b, lat); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.arg1 = '0;
    bus.arg2 = '0;
    bus.start = 1'b0;
    test_reset();
    test_directed();
    test_invalid();
    test_random();
    test_back_to_back();
    test_arg_change();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
